// File: rtl/pc_sched_if.sv
// Request/stall/redirect bundle between the fetch sequencer and its clients.
// The master side raises redirect and stall causes; the slave side is pc_sched.
interface pc_sched_if;
    logic        exc_req;
    logic [31:0] exc_vec;
    logic        br_req;
    logic [31:0] br_target;
    logic        j_req;
    logic        j_reg;
    logic [31:0] j_target;
    logic        hz_stall;
    logic        imem_wait;
    logic        md_start;
    logic        md_use;
    logic        stall;
    logic [2:0]  NPCOP;
    logic [31:0] NPC;
    logic        flush_ifid;
    logic        flush_idex;
    logic        flush_exmem;
    logic        busy_md;

    modport master (
        output exc_req, exc_vec, br_req, br_target, j_req, j_reg, j_target,
               hz_stall, imem_wait, md_start, md_use,
        input  stall, NPCOP, NPC, flush_ifid, flush_idex, flush_exmem, busy_md
    );

    modport slave (
        input  exc_req, exc_vec, br_req, br_target, j_req, j_reg, j_target,
               hz_stall, imem_wait, md_start, md_use,
        output stall, NPCOP, NPC, flush_ifid, flush_idex, flush_exmem, busy_md
    );
endinterface

// File: rtl/pc_sched.sv
// Fetch sequencing controller: prioritises redirects, merges stall causes and
// parks a blocked redirect until the PC can take it.
module pc_sched #(
    parameter int MD_LAT    = 5,
    parameter int EXC_FLUSH = 2
) (
    input  logic       clk,
    input  logic       rst,
    pc_sched_if.slave  bus
);

    localparam logic [2:0] OP_SEQ = 3'b000;
    localparam logic [2:0] OP_BR  = 3'b001;
    localparam logic [2:0] OP_J   = 3'b010;
    localparam logic [2:0] OP_JR  = 3'b011;
    localparam logic [2:0] OP_EXC = 3'b100;

    localparam int MDW = $clog2(MD_LAT + 1);
    localparam int ECW = (EXC_FLUSH > 1) ? $clog2(EXC_FLUSH) : 1;

    typedef enum logic [1:0] {RUN, HOLD, EXCF} state_t;

    state_t          state;
    logic [2:0]      pend_op;
    logic [31:0]     pend_tgt;
    logic [MDW-1:0]  md_cnt;
    logic [ECW-1:0]  exc_cnt;

    logic [2:0]      fresh_op;
    logic [31:0]     fresh_tgt;
    logic [2:0]      sel_op;
    logic [31:0]     sel_tgt;
    logic            md_busy;
    logic            stall_raw;
    logic            blocked;
    logic            issue;

    function automatic logic [1:0] rank(input logic [2:0] op);
        case (op)
            OP_EXC:      rank = 2'd3;
            OP_BR:       rank = 2'd2;
            OP_J, OP_JR: rank = 2'd1;
            default:     rank = 2'd0;
        endcase
    endfunction

    assign md_busy   = (md_cnt != '0);
    assign stall_raw = bus.hz_stall | bus.imem_wait | (md_busy & bus.md_use);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        fresh_op  = OP_SEQ;
        fresh_tgt = '0;
        if (bus.exc_req) begin
            fresh_op  = OP_EXC;
            fresh_tgt = bus.exc_vec;
        end else if (state != EXCF) begin
            // Branch/jump instructions behind an exception are being flushed.
            if (bus.br_req) begin
                fresh_op  = OP_BR;
                fresh_tgt = bus.br_target;
            end else if (bus.j_req) begin
                fresh_op  = bus.j_reg ? OP_JR : OP_J;
                fresh_tgt = bus.j_target;
            end
        end

        sel_op  = fresh_op;
        sel_tgt = fresh_tgt;
        if (state == HOLD && rank(fresh_op) <= rank(pend_op)) begin
            sel_op  = pend_op;
            sel_tgt = pend_tgt;
        end

        // An exception only waits for instruction memory.
        blocked = (sel_op == OP_EXC) ? bus.imem_wait : stall_raw;
        issue   = (sel_op != OP_SEQ) && !blocked;
    end

    assign bus.stall       = rst & ~issue & stall_raw;
    assign bus.NPCOP       = (rst && issue) ? sel_op  : OP_SEQ;
    assign bus.NPC         = (rst && issue) ? sel_tgt : '0;
    assign bus.flush_ifid  = rst & issue;
    assign bus.flush_idex  = rst & issue & ((sel_op == OP_BR) | (sel_op == OP_EXC));
    assign bus.flush_exmem = rst & ((issue & (sel_op == OP_EXC)) | (state == EXCF));
    assign bus.busy_md     = rst & md_busy;

    always_ff @(posedge clk) begin
        // NOTE: all control state is cleared on reset; a reset edge beats any request.
        if (!rst) begin
            state    <= RUN;
            pend_op  <= OP_SEQ;
            pend_tgt <= '0;
            md_cnt   <= '0;
            exc_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (bus.md_start) begin
                md_cnt <= MDW'(MD_LAT);
            end else if (md_busy) begin
                md_cnt <= md_cnt - MDW'(1);
            end

            if (issue) begin
                pend_op  <= OP_SEQ;
                pend_tgt <= '0;
                if (sel_op == OP_EXC && EXC_FLUSH > 1) begin
                    state   <= EXCF;
                    exc_cnt <= ECW'(EXC_FLUSH - 1);
                end else begin
                    state   <= RUN;
                    exc_cnt <= '0;
                end
            end else if (sel_op != OP_SEQ) begin
                state    <= HOLD;
                pend_op  <= sel_op;
                pend_tgt <= sel_tgt;
                exc_cnt  <= '0;
            end else if (state == EXCF) begin
                exc_cnt <= exc_cnt - ECW'(1);
                if (exc_cnt <= ECW'(1)) begin
                    state <= RUN;
                end
            end else begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_pc_sched.sv
// Directed bench for pc_sched: a per-cycle vector table followed by
// hand-written multiply/divide, exception-vs-stall and reset sequences.
module tb_pc_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sched_if bus ();

    pc_sched #(.MD_LAT(5), .EXC_FLUSH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        bit          r, e, b, j, jr, hz, iw, ms, mu;
        logic [31:0] bt, jt;
        logic [39:0] exp;
    } vec_t;

    // Expected output bundle: {stall, NPCOP, NPC, ifid, idex, exmem, busy_md}.
    function automatic logic [39:0] ex(input bit st, input logic [2:0] op,
                                       input logic [31:0] npc, input logic [2:0] fl,
                                       input bit busy);
        return {st, op, npc, fl, busy};
    endfunction

    function automatic logic [39:0] outs();
        return {bus.stall, bus.NPCOP, bus.NPC, bus.flush_ifid, bus.flush_idex,
                bus.flush_exmem, bus.busy_md};
    endfunction

    function automatic vec_t mk(input string name,
                                input bit r, e, b, j, jr, hz, iw, ms, mu,
                                input logic [31:0] bt, jt, input logic [39:0] exp);
        vec_t v;
        v.name = name;
        v.r = r; v.e = e; v.b = b; v.j = j; v.jr = jr;
        v.hz = hz; v.iw = iw; v.ms = ms; v.mu = mu;
        v.bt = bt; v.jt = jt; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual st=%0b op=%03b npc=%08h fl=%03b busy=%0b required st=%0b op=%03b npc=%08h fl=%03b busy=%0b",
                     name, act[39], act[38:36], act[35:4], act[3:1], act[0],
                     exp[39], exp[38:36], exp[35:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst           = v.r;
        bus.exc_req   = v.e;
        bus.br_req    = v.b;
        bus.br_target = v.bt;
        bus.j_req     = v.j;
        bus.j_reg     = v.jr;
        bus.j_target  = v.jt;
        bus.hz_stall  = v.hz;
        bus.imem_wait = v.iw;
        bus.md_start  = v.ms;
        bus.md_use    = v.mu;
        #1;
    endtask

    task automatic step_check(input vec_t v);
        apply(v);
        check(v.name, outs(), v.exp);
    endtask

    localparam logic [39:0] IDLE = 40'd0;
    vec_t tbl[24];
    vec_t v;
    logic [15:0] ms_pat;
    logic [15:0] busy_pat;

    initial begin
        rst = 1'b0;
        bus.exc_req = 0; bus.exc_vec = 32'h180; bus.br_req = 0; bus.br_target = 0;
        bus.j_req = 0; bus.j_reg = 0; bus.j_target = 0; bus.hz_stall = 0;
        bus.imem_wait = 0; bus.md_start = 0; bus.md_use = 0;

        //            name          r e b j jr hz iw ms mu  bt      jt
        tbl[0]  = mk("rst_req",    0,1,1,1,0, 0,0,1,0, 32'h40, 32'h1000, IDLE);
        tbl[1]  = mk("rst_stall",  0,0,1,0,0, 1,0,0,1, 32'h40, 32'h0,    IDLE);
        tbl[2]  = mk("post_rst",   1,0,0,0,0, 0,0,0,0, 32'h0,  32'h0,    IDLE);
        tbl[3]  = mk("br_issue",   1,0,1,0,0, 0,0,0,0, 32'h40, 32'h0,    ex(0,3'b001,32'h40,3'b110,0));
        tbl[4]  = mk("br_after",   1,0,0,0,0, 0,0,0,0, 32'h0,  32'h0,    IDLE);
        tbl[5]  = mk("j_blk1",     1,0,0,1,0, 1,0,0,0, 32'h0,  32'h1000, ex(1,3'b000,32'h0,3'b000,0));
        tbl[6]  = mk("j_blk2",     1,0,0,1,0, 1,0,0,0, 32'h0,  32'h2000, ex(1,3'b000,32'h0,3'b000,0));
        tbl[7]  = mk("j_release",  1,0,0,0,0, 0,0,0,0, 32'h0,  32'h0,    ex(0,3'b010,32'h1000,3'b100,0));
        tbl[8]  = mk("j_after",    1,0,0,0,0, 0,0,0,0, 32'h0,  32'h0,    IDLE);
        tbl[9]  = mk("jr_blk",     1,0,0,1,1, 0,1,0,0, 32'h0,  32'h3000, ex(1,3'b000,32'h0,3'b000,0));
        tbl[10] = mk("br_replace", 1,0,1,0,0, 0,1,0,0, 32'h44, 32'h0,    ex(1,3'b000,32'h0,3'b000,0));
        tbl[11] = mk("pend_br",    1,0,0,1,0, 0,0,0,0, 32'h0,  32'h5000, ex(0,3'b001,32'h44,3'b110,0));
        tbl[12] = mk("idle_a",     1,0,0,0,0, 0,0,0,0, 32'h0,  32'h0,    IDLE);
        tbl[13] = mk("prio_exc",   1,1,1,1,0, 1,0,0,0, 32'h40, 32'h1000, ex(0,3'b100,32'h180,3'b111,0));
        tbl[14] = mk("excf_drop",  1,0,1,0,0, 0,0,0,0, 32'h48, 32'h0,    ex(0,3'b000,32'h0,3'b001,0));
        tbl[15] = mk("excf_end",   1,0,0,0,0, 0,0,0,0, 32'h0,  32'h0,    IDLE);
        tbl[16] = mk("exc_iw1",    1,1,0,0,0, 0,1,0,0, 32'h0,  32'h0,    ex(1,3'b000,32'h0,3'b000,0));
        tbl[17] = mk("exc_iw2",    1,0,0,0,0, 0,1,0,0, 32'h0,  32'h0,    ex(1,3'b000,32'h0,3'b000,0));
        tbl[18] = mk("exc_rel",    1,0,0,0,0, 0,0,0,0, 32'h0,  32'h0,    ex(0,3'b100,32'h180,3'b111,0));
        tbl[19] = mk("exc_again",  1,1,0,0,0, 0,0,0,0, 32'h0,  32'h0,    ex(0,3'b100,32'h180,3'b111,0));
        tbl[20] = mk("excf_drain", 1,0,0,0,0, 0,0,0,0, 32'h0,  32'h0,    ex(0,3'b000,32'h0,3'b001,0));
        tbl[21] = mk("excf_done",  1,0,0,0,0, 0,0,0,0, 32'h0,  32'h0,    IDLE);
        tbl[22] = mk("jr_issue",   1,0,0,1,1, 0,0,0,0, 32'h0,  32'h600,  ex(0,3'b011,32'h600,3'b100,0));
        tbl[23] = mk("hz_only",    1,0,0,0,0, 1,0,0,0, 32'h0,  32'h0,    ex(1,3'b000,32'h0,3'b000,0));

        for (int i = 0; i < 24; i++) step_check(tbl[i]);

        // Plain 5-cycle busy window, then a reload two cycles into the next one.
        ms_pat   = 16'b0000_0010_1000_0001;
        busy_pat = 16'b0111_1111_0011_1110;
        for (int i = 0; i < 16; i++) begin
            v = mk($sformatf("md_cyc%0d", i), 1,0,0,0,0, 0,0,ms_pat[i],1, 32'h0, 32'h0,
                   ex(busy_pat[i], 3'b000, 32'h0, 3'b000, busy_pat[i]));
            step_check(v);
        end

        // Exception during a mult/div stall issues at once.
        bus.exc_vec = 32'h200;
        step_check(mk("mdx_start", 1,0,0,0,0, 0,0,1,0, 0, 0, IDLE));
        step_check(mk("mdx_stall", 1,0,0,0,0, 0,0,0,1, 0, 0, ex(1,3'b000,32'h0,3'b000,1)));
        step_check(mk("mdx_exc",   1,1,0,0,0, 0,0,0,1, 0, 0, ex(0,3'b100,32'h200,3'b111,1)));
        step_check(mk("mdx_excf",  1,0,0,0,0, 0,0,0,1, 0, 0, ex(1,3'b000,32'h0,3'b001,1)));
        step_check(mk("mdx_c4",    1,0,0,0,0, 0,0,0,1, 0, 0, ex(1,3'b000,32'h0,3'b000,1)));
        step_check(mk("mdx_c5",    1,0,0,0,0, 0,0,0,1, 0, 0, ex(1,3'b000,32'h0,3'b000,1)));
        step_check(mk("mdx_done",  1,0,0,0,0, 0,0,0,1, 0, 0, IDLE));
        bus.exc_vec = 32'h180;

        // Reset mid-HOLD discards the parked jump.
        step_check(mk("rh_hold",   1,0,0,1,0, 1,0,0,0, 0, 32'h700, ex(1,3'b000,32'h0,3'b000,0)));
        step_check(mk("rh_rst",    0,0,0,0,0, 1,0,0,0, 0, 0, IDLE));
        step_check(mk("rh_clean",  1,0,0,0,0, 0,0,0,0, 0, 0, IDLE));

        // Reset mid-EXCF discards the flush drain.
        step_check(mk("re_exc",    1,1,0,0,0, 0,0,0,0, 0, 0, ex(0,3'b100,32'h180,3'b111,0)));
        step_check(mk("re_rst",    0,0,0,0,0, 0,0,0,0, 0, 0, IDLE));
        step_check(mk("re_clean",  1,0,0,0,0, 0,0,0,0, 0, 0, IDLE));

        // Reset clears the mult/div counter.
        step_check(mk("rm_start",  1,0,0,0,0, 0,0,1,0, 0, 0, IDLE));
        step_check(mk("rm_rst",    0,0,0,0,0, 0,0,0,1, 0, 0, IDLE));
        step_check(mk("rm_clean",  1,0,0,0,0, 0,0,0,1, 0, 0, IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
